// File: rtl/threshold_pkg.sv
// -----------------------------------------------------------------------------
// threshold_pkg
// Shared definitions for the YCbCr threshold binarization stage:
//   - shadow-register address map for the configuration port
//   - configuration controller FSM state encoding
//   - default threshold values (also used by the binarization datapath)
// No ports (package).
// -----------------------------------------------------------------------------
package threshold_pkg;

    localparam int TH_DW = 8;

    // Configuration port address map; 6 and 7 are reserved.
    localparam logic [2:0] TH_ADDR_Y_TH  = 3'd0;
    localparam logic [2:0] TH_ADDR_Y_TL  = 3'd1;
    localparam logic [2:0] TH_ADDR_CB_TH = 3'd2;
    localparam logic [2:0] TH_ADDR_CB_TL = 3'd3;
    localparam logic [2:0] TH_ADDR_CR_TH = 3'd4;
    localparam logic [2:0] TH_ADDR_CR_TL = 3'd5;

    // Commit FSM states.
    typedef enum logic [1:0] {
        TH_ST_IDLE  = 2'd0,
        TH_ST_PEND  = 2'd1,
        TH_ST_APPLY = 2'd2
    } th_state_e;

    // Power-on thresholds.
    localparam logic [TH_DW-1:0] TH_Y_TH_DEF  = 8'd150;
    localparam logic [TH_DW-1:0] TH_Y_TL_DEF  = 8'd40;
    localparam logic [TH_DW-1:0] TH_CB_TH_DEF = 8'd155;
    localparam logic [TH_DW-1:0] TH_CB_TL_DEF = 8'd100;
    localparam logic [TH_DW-1:0] TH_CR_TH_DEF = 8'd240;
    localparam logic [TH_DW-1:0] TH_CR_TL_DEF = 8'd160;

endpackage : threshold_pkg

// File: rtl/vsync_edge_det.sv
// -----------------------------------------------------------------------------
// vsync_edge_det
// Registers i_vsync and emits a registered one-cycle frame-start pulse on its
// rising edge. o_fs is high in the cycle after i_vsync is first sampled high.
// Ports:
//   pixelclk  in  pixel clock (rising edge)
//   reset_n   in  asynchronous active-low reset
//   i_vsync   in  vertical sync from the datapath input
//   o_fs      out frame-start pulse (registered)
// -----------------------------------------------------------------------------
module vsync_edge_det (
    input  logic pixelclk,
    input  logic reset_n,
    input  logic i_vsync,
    output logic o_fs
);

    logic r_vsync_d;
    logic r_fs;

    // Delay vsync by one cycle and register the rising-edge decode.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_d <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_fs      <= i_vsync & ~r_vsync_d;
        end
    end

    assign o_fs = r_fs;

endmodule : vsync_edge_det

// File: rtl/threshold_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// threshold_cfg_ctrl
// Run-time configuration controller for the YCbCr threshold binarization
// stage. Six shadow thresholds are written through a valid/ready port and are
// copied to the active outputs only at a frame start, so a frame never sees a
// mixed threshold set. A commit is rejected (cfg_err) when any low threshold
// exceeds its high threshold.
//
// Optional feature macro: TH_HIT_CNT_EN -- when defined, per-frame hit pixels
// (i_de && i_hit) are counted and reported on hit_cnt at each frame start;
// otherwise hit_cnt is tied to zero and i_hit is ignored.
//
// Ports:
//   pixelclk        in   pixel clock (rising edge)
//   reset_n         in   asynchronous active-low reset
//   cfg_valid       in   shadow write request
//   cfg_ready       out  write accepted when high with cfg_valid
//   cfg_addr [2:0]  in   shadow register select (6/7 reserved, discarded)
//   cfg_data [DW]   in   write data
//   commit_req      in   pulse: arm a commit for the next frame start
//   i_vsync, i_de   in   video timing
//   i_hit           in   pixel-in-range flag from the datapath
//   y_th .. cr_tl   out  active thresholds
//   commit_pending  out  a commit is armed
//   cfg_err         out  sticky: last commit rejected
//   frame_cnt [16]  out  frame starts seen (wraps)
//   hit_cnt [CNT_W] out  hits in the last completed frame
// -----------------------------------------------------------------------------
module threshold_cfg_ctrl
    import threshold_pkg::*;
#(
    parameter int             DW        = 8,
    parameter logic [DW-1:0]  Y_TH_RST  = DW'(TH_Y_TH_DEF),
    parameter logic [DW-1:0]  Y_TL_RST  = DW'(TH_Y_TL_DEF),
    parameter logic [DW-1:0]  CB_TH_RST = DW'(TH_CB_TH_DEF),
    parameter logic [DW-1:0]  CB_TL_RST = DW'(TH_CB_TL_DEF),
    parameter logic [DW-1:0]  CR_TH_RST = DW'(TH_CR_TH_DEF),
    parameter logic [DW-1:0]  CR_TL_RST = DW'(TH_CR_TL_DEF),
    parameter int             CNT_W     = 22
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_addr,
    input  logic [DW-1:0]    cfg_data,
    input  logic             commit_req,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic             i_hit,
    output logic [DW-1:0]    y_th,
    output logic [DW-1:0]    y_tl,
    output logic [DW-1:0]    cb_th,
    output logic [DW-1:0]    cb_tl,
    output logic [DW-1:0]    cr_th,
    output logic [DW-1:0]    cr_tl,
    output logic             commit_pending,
    output logic             cfg_err,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    logic          w_fs;
    th_state_e     r_state;
    th_state_e     w_next_state;
    logic          w_cfg_ready_nxt;
    logic          w_pending_nxt;
    logic          w_apply;
    logic          w_wr_en;
    logic          w_cfg_ok;

    logic          r_cfg_ready;
    logic          r_commit_pending;
    logic          r_cfg_err;
    logic [15:0]   r_frame_cnt;

    logic [DW-1:0] r_sh_y_th, r_sh_y_tl, r_sh_cb_th, r_sh_cb_tl, r_sh_cr_th, r_sh_cr_tl;
    logic [DW-1:0] r_y_th, r_y_tl, r_cb_th, r_cb_tl, r_cr_th, r_cr_tl;

    vsync_edge_det u_vsync_edge_det (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .i_vsync  (i_vsync),
        .o_fs     (w_fs)
    );

    // Writes only land while the registered ready is high, so the APPLY cycle
    // always sees a stable shadow bank.
    assign w_wr_en  = cfg_valid & r_cfg_ready;
    assign w_cfg_ok = (r_sh_y_tl  <= r_sh_y_th)  &&
                      (r_sh_cb_tl <= r_sh_cb_th) &&
                      (r_sh_cr_tl <= r_sh_cr_th);

    // FSM state register.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TH_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic. A commit_req coinciding with fs in IDLE only arms,
    // so the commit lands on the following frame start.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TH_ST_IDLE: begin
                if (commit_req) begin
                    w_next_state = TH_ST_PEND;
                end else begin
                    w_next_state = TH_ST_IDLE;
                end
            end
            TH_ST_PEND: begin
                if (w_fs) begin
                    w_next_state = TH_ST_APPLY;
                end else begin
                    w_next_state = TH_ST_PEND;
                end
            end
            TH_ST_APPLY: w_next_state = TH_ST_IDLE;
            default:     w_next_state = TH_ST_IDLE;
        endcase
    end

    // FSM output decode; ready/pending are computed from the next state so
    // their registered versions line up with the state they describe.
    always_comb begin
        w_cfg_ready_nxt = (w_next_state != TH_ST_APPLY);
        w_pending_nxt   = (w_next_state == TH_ST_PEND);
        w_apply         = (r_state == TH_ST_APPLY);
    end

    // Registered handshake/status outputs.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_ready      <= 1'b1;
            r_commit_pending <= 1'b0;
        end else begin
            r_cfg_ready      <= w_cfg_ready_nxt;
            r_commit_pending <= w_pending_nxt;
        end
    end

    // Shadow bank writes; reserved addresses are accepted and dropped.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_y_th  <= Y_TH_RST;
            r_sh_y_tl  <= Y_TL_RST;
            r_sh_cb_th <= CB_TH_RST;
            r_sh_cb_tl <= CB_TL_RST;
            r_sh_cr_th <= CR_TH_RST;
            r_sh_cr_tl <= CR_TL_RST;
        end else if (w_wr_en) begin
            case (cfg_addr)
                TH_ADDR_Y_TH:  r_sh_y_th  <= cfg_data;
                TH_ADDR_Y_TL:  r_sh_y_tl  <= cfg_data;
                TH_ADDR_CB_TH: r_sh_cb_th <= cfg_data;
                TH_ADDR_CB_TL: r_sh_cb_tl <= cfg_data;
                TH_ADDR_CR_TH: r_sh_cr_th <= cfg_data;
                TH_ADDR_CR_TL: r_sh_cr_tl <= cfg_data;
                default: begin
                end
            endcase
        end
    end

    // Active bank and error flag, updated only in the APPLY cycle.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_y_th    <= Y_TH_RST;
            r_y_tl    <= Y_TL_RST;
            r_cb_th   <= CB_TH_RST;
            r_cb_tl   <= CB_TL_RST;
            r_cr_th   <= CR_TH_RST;
            r_cr_tl   <= CR_TL_RST;
            r_cfg_err <= 1'b0;
        end else if (w_apply) begin
            if (w_cfg_ok) begin
                r_y_th    <= r_sh_y_th;
                r_y_tl    <= r_sh_y_tl;
                r_cb_th   <= r_sh_cb_th;
                r_cb_tl   <= r_sh_cb_tl;
                r_cr_th   <= r_sh_cr_th;
                r_cr_tl   <= r_sh_cr_tl;
                r_cfg_err <= 1'b0;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // Frame-start counter, free-running wrap.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_fs) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

`ifdef TH_HIT_CNT_EN
    localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

    logic             w_hit;
    logic [CNT_W-1:0] r_hit_acc;
    logic [CNT_W-1:0] r_hit_cnt;

    assign w_hit = i_de & i_hit;

    // Per-frame hit accumulator; a hit in the fs cycle belongs to the new frame.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_acc <= {CNT_W{1'b0}};
            r_hit_cnt <= {CNT_W{1'b0}};
        end else if (w_fs) begin
            r_hit_cnt <= r_hit_acc;
            r_hit_acc <= w_hit ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (w_hit && (r_hit_acc != HIT_MAX)) begin
            r_hit_acc <= r_hit_acc + CNT_W'(1);
        end
    end

    assign hit_cnt = r_hit_cnt;
`else
    logic w_unused_hit_in;

    assign w_unused_hit_in = &{1'b0, i_de, i_hit};
    assign hit_cnt         = {CNT_W{1'b0}};
`endif

    assign cfg_ready      = r_cfg_ready;
    assign commit_pending = r_commit_pending;
    assign cfg_err        = r_cfg_err;
    assign frame_cnt      = r_frame_cnt;
    assign y_th           = r_y_th;
    assign y_tl           = r_y_tl;
    assign cb_th          = r_cb_th;
    assign cb_tl          = r_cb_tl;
    assign cr_th          = r_cr_th;
    assign cr_tl          = r_cr_tl;

endmodule : threshold_cfg_ctrl

// File: tb/tb_threshold_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_threshold_cfg_ctrl
// Self-checking bench for threshold_cfg_ctrl. Expected active-threshold sets
// are pushed to a scoreboard when a commit is armed and a vsync is driven; a
// monitor pops and compares whenever the DUT leaves its APPLY cycle (cfg_ready
// rising). Directed checks cover reset, exact commit latency, stalls, the
// commit/fs coincidence, reset while pending and the optional hit counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_threshold_cfg_ctrl;
    localparam int DW    = 8;
    localparam int CNT_W = 22;

    typedef struct packed {
        logic [5:0][7:0] act;
        logic            err;
    } exp_t;

    logic             pixelclk = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_addr;
    logic [DW-1:0]    cfg_data;
    logic             commit_req;
    logic             i_vsync;
    logic             i_de;
    logic             i_hit;
    logic [DW-1:0]    y_th, y_tl, cb_th, cb_tl, cr_th, cr_tl;
    logic             commit_pending;
    logic             cfg_err;
    logic [15:0]      frame_cnt;
    logic [CNT_W-1:0] hit_cnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    exp_t             sb_q[$];
    logic [5:0][7:0]  m_shadow;
    logic [5:0][7:0]  m_active;
    logic             m_err;
    int               m_frames;
    logic [5:0][7:0]  rst_vals;
    logic             prev_ready;
    int               st;

    threshold_cfg_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
        .pixelclk       (pixelclk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .commit_req     (commit_req),
        .i_vsync        (i_vsync),
        .i_de           (i_de),
        .i_hit          (i_hit),
        .y_th           (y_th),
        .y_tl           (y_tl),
        .cb_th          (cb_th),
        .cb_tl          (cb_tl),
        .cr_th          (cr_th),
        .cr_tl          (cr_tl),
        .commit_pending (commit_pending),
        .cfg_err        (cfg_err),
        .frame_cnt      (frame_cnt),
        .hit_cnt        (hit_cnt)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    function automatic logic set_ok(input logic [5:0][7:0] s);
        return (s[1] <= s[0]) && (s[3] <= s[2]) && (s[5] <= s[4]);
    endfunction

    // Model the outcome of the armed commit and queue it.
    task automatic push_commit();
        exp_t e;
        if (set_ok(m_shadow)) begin
            m_active = m_shadow;
            m_err    = 1'b0;
        end else begin
            m_err    = 1'b1;
        end
        e.act = m_active;
        e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, output int stalls);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        stalls    = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pixelclk);
            if (cfg_ready) break;
            stalls++;
        end
        check_eq("wr_accept", {31'd0, cfg_ready}, 32'd1);
        tick();
        cfg_valid = 1'b0;
        if (a < 3'd6) m_shadow[a] = d;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check_eq("sb_drain", sb_q.size(), 32'd0);
    endtask

    task automatic run_frame();
        i_vsync = 1'b1;
        m_frames++;
        repeat (3) tick();
        i_vsync = 1'b0;
        repeat (3) tick();
        wait_drain();
    endtask

    task automatic model_reset();
        m_shadow = rst_vals;
        m_active = rst_vals;
        m_err    = 1'b0;
        m_frames = 0;
    endtask

    // Scoreboard monitor: the cycle after APPLY is the only time cfg_ready rises.
    always @(negedge pixelclk) begin
        exp_t e;
        logic [5:0][7:0] obs;
        if (reset_n && cfg_ready && !prev_ready) begin
            check_eq("sb_entry_avail", {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                obs = {cr_tl, cr_th, cb_tl, cb_th, y_tl, y_th};
                for (int k = 0; k < 6; k++) check_eq($sformatf("sb_th%0d", k), obs[k], e.act[k]);
                check_eq("sb_err", {31'd0, cfg_err}, {31'd0, e.err});
            end
        end
        prev_ready <= cfg_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_vals   = {8'd160, 8'd240, 8'd100, 8'd155, 8'd40, 8'd150};
        prev_ready = 1'b1;
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_addr   = 3'd0;
        cfg_data   = 8'd0;
        commit_req = 1'b0;
        i_vsync    = 1'b0;
        i_de       = 1'b0;
        i_hit      = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        @(negedge pixelclk);
        check_eq("rst_y_th",  y_th,  32'd150);
        check_eq("rst_y_tl",  y_tl,  32'd40);
        check_eq("rst_cb_th", cb_th, 32'd155);
        check_eq("rst_cb_tl", cb_tl, 32'd100);
        check_eq("rst_cr_th", cr_th, 32'd240);
        check_eq("rst_cr_tl", cr_tl, 32'd160);
        check_eq("rst_ready", {31'd0, cfg_ready}, 32'd1);
        check_eq("rst_err",   {31'd0, cfg_err}, 32'd0);
        check_eq("rst_pend",  {31'd0, commit_pending}, 32'd0);
        check_eq("rst_frame", frame_cnt, 32'd0);
        check_eq("rst_hit",   hit_cnt, 32'd0);
        tick();

        // Good commit with exact latency from the vsync edge
        cfg_write(3'd0, 8'd200, st);
        cfg_write(3'd1, 8'd10, st);
        pulse_commit();
        @(negedge pixelclk);
        check_eq("pend_armed", {31'd0, commit_pending}, 32'd1);
        tick();
        push_commit();
        i_vsync = 1'b1;
        m_frames++;
        @(negedge pixelclk);
        check_eq("y_th_cycN",  y_th, 32'd150);
        check_eq("pend_cycN",  {31'd0, commit_pending}, 32'd1);
        @(negedge pixelclk);
        check_eq("y_th_cycN1", y_th, 32'd150);
        @(negedge pixelclk);
        check_eq("apply_ready", {31'd0, cfg_ready}, 32'd0);
        check_eq("apply_pend",  {31'd0, commit_pending}, 32'd0);
        check_eq("y_th_apply",  y_th, 32'd150);
        @(negedge pixelclk);
        check_eq("y_th_new", y_th, 32'd200);
        check_eq("y_tl_new", y_tl, 32'd10);
        tick();
        i_vsync = 1'b0;
        repeat (2) tick();
        wait_drain();

        // Rejected commit, then a valid commit clears the error
        cfg_write(3'd3, 8'd180, st);
        pulse_commit();
        push_commit();
        run_frame();
        @(negedge pixelclk);
        check_eq("rej_err",   {31'd0, cfg_err}, 32'd1);
        check_eq("rej_cb_tl", cb_tl, 32'd100);
        tick();
        cfg_write(3'd3, 8'd150, st);
        pulse_commit();
        push_commit();
        run_frame();
        @(negedge pixelclk);
        check_eq("clr_err", {31'd0, cfg_err}, 32'd0);
        tick();

        // commit_req in the fs cycle: not applied this frame, applied next
        cfg_write(3'd0, 8'd77, st);
        i_vsync = 1'b1;
        m_frames++;
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (4) tick();
        @(negedge pixelclk);
        check_eq("coinc_pend", {31'd0, commit_pending}, 32'd1);
        check_eq("coinc_y_th", y_th, {24'd0, m_active[0]});
        tick();
        i_vsync = 1'b0;
        repeat (2) tick();
        push_commit();
        run_frame();

        // Write held across APPLY stalls exactly one cycle
        pulse_commit();
        push_commit();
        i_vsync = 1'b1;
        m_frames++;
        tick();
        tick();
        cfg_write(3'd4, 8'd250, st);
        check_eq("stall_cycles", st, 32'd1);
        i_vsync = 1'b0;
        repeat (2) tick();
        wait_drain();
        pulse_commit();
        push_commit();
        run_frame();

        // Reserved address and overwrite while pending
        pulse_commit();
        cfg_write(3'd7, 8'h55, st);
        cfg_write(3'd0, 8'd90, st);
        cfg_write(3'd0, 8'd120, st);
        push_commit();
        run_frame();
        @(negedge pixelclk);
        check_eq("ovw_y_th", y_th, 32'd120);
        tick();

        // Random commits, mix of accepted and rejected
        for (int r = 0; r < 6; r++) begin
            cfg_write(3'($urandom_range(0, 5)), 8'($urandom), st);
            cfg_write(3'($urandom_range(0, 5)), 8'($urandom), st);
            pulse_commit();
            push_commit();
            run_frame();
        end

        // Reset while a commit is pending
        cfg_write(3'd0, 8'd33, st);
        pulse_commit();
        tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        model_reset();
        @(negedge pixelclk);
        check_eq("rstp_pend",  {31'd0, commit_pending}, 32'd0);
        check_eq("rstp_y_th",  y_th, 32'd150);
        check_eq("rstp_frame", frame_cnt, 32'd0);
        tick();
        run_frame();
        pulse_commit();
        push_commit();
        run_frame();

        // Hit counting: 300 hits in a 1000-cycle active run, then ungated hits
        i_de = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            i_hit = (i < 300);
            tick();
        end
        i_de  = 1'b0;
        i_hit = 1'b1;
        repeat (50) tick();
        i_hit = 1'b0;
        run_frame();
        @(negedge pixelclk);
`ifdef TH_HIT_CNT_EN
        check_eq("hit_cnt", hit_cnt, 32'd300);
`else
        check_eq("hit_cnt", hit_cnt, 32'd0);
`endif
        check_eq("frame_cnt", frame_cnt, m_frames);
        check_eq("sb_final", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_threshold_cfg_ctrl
